// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the MEM stage (master) and the data-memory
// responder (slave).
interface data_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busy_wait;
    logic        misaligned;

    modport master (
        output mem_read, mem_write, func3, address, write_data,
        input  read_data, busy_wait, misaligned
    );

    modport slave (
        input  mem_read, mem_write, func3, address, write_data,
        output read_data, busy_wait, misaligned
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-addressed little-endian array that completes
// each load/store after LATENCY stall cycles, then spends one DONE cycle
// presenting the result before accepting the next request.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [3:0] CNT_START = 4'(LATENCY - 1);
    localparam bit         LAT_ONE   = (LATENCY == 1);

    // Halfword needs addr[0]=0, word needs addr[1:0]=0; HU (101) only exists for loads.
    function automatic logic is_misaligned(input logic wr, input logic [2:0] f3,
                                           input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (f3)
            3'b001:  m = a[0];
            3'b101:  m = wr ? 1'b0 : a[0];
            3'b010:  m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Little-endian byte selection followed by sign/zero extension.
    function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                                input logic [7:0] b0, input logic [7:0] b1,
                                                input logic [7:0] b2, input logic [7:0] b3);
        logic [31:0] r;
        r = {b3, b2, b1, b0};
        case (f3)
            3'b000:  r = {{24{b0[7]}}, b0};
            3'b100:  r = {24'h000000, b0};
            3'b001:  r = {{16{b1[7]}}, b1, b0};
            3'b101:  r = {16'h0000, b1, b0};
            default: r = {b3, b2, b1, b0};
        endcase
        return r;
    endfunction

    logic [1:0]            state_r;
    logic [3:0]            cnt_r;
    logic                  write_r;
    logic [2:0]            func3_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           wdata_r;
    logic [31:0]           read_data_r;
    logic                  misaligned_r;
    logic [7:0]            mem_r [0:DEPTH-1];

    logic                  req_s;
    logic                  commit_s;
    logic                  c_write_s;
    logic [2:0]            c_func3_s;
    logic [ADDR_WIDTH-1:0] c_addr_s;
    logic [ADDR_WIDTH-1:0] c_addr1_s;
    logic [ADDR_WIDTH-1:0] c_addr2_s;
    logic [ADDR_WIDTH-1:0] c_addr3_s;
    logic [31:0]           c_wdata_s;
    logic                  c_mis_s;
    logic [31:0]           load_data_s;
    logic                  busy_wait_s;

    // Commit uses the live inputs when LATENCY=1 (commit happens at the latch edge).
    always_comb begin
        req_s     = bus.mem_read | bus.mem_write;
        commit_s  = 1'b0;
        c_write_s = write_r;
        c_func3_s = func3_r;
        c_addr_s  = addr_r;
        c_wdata_s = wdata_r;
        if (state_r == ST_IDLE) begin
            commit_s  = LAT_ONE & req_s;
            c_write_s = bus.mem_write;
            c_func3_s = bus.func3;
            c_addr_s  = bus.address[ADDR_WIDTH-1:0];
            c_wdata_s = bus.write_data;
        end else if (state_r == ST_ACCESS) begin
            commit_s = (cnt_r == 4'd1);
        end else begin
            commit_s = 1'b0;
        end
        c_addr1_s   = c_addr_s + ADDR_WIDTH'(1);
        c_addr2_s   = c_addr_s + ADDR_WIDTH'(2);
        c_addr3_s   = c_addr_s + ADDR_WIDTH'(3);
        c_mis_s     = is_misaligned(c_write_s, c_func3_s, c_addr_s[1:0]);
        load_data_s = extend_load(c_func3_s, mem_r[c_addr_s], mem_r[c_addr1_s],
                                  mem_r[c_addr2_s], mem_r[c_addr3_s]);
    end

    // Stall request: follows the request in IDLE, always high while accessing, low in reset.
    always_comb begin
        busy_wait_s = 1'b0;
        if (!rst_n) begin
            busy_wait_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   busy_wait_s = req_s;
                ST_ACCESS: busy_wait_s = 1'b1;
                ST_DONE:   busy_wait_s = 1'b0;
                default:   busy_wait_s = 1'b0;
            endcase
        end
    end

    // Sequencer: latch the request in IDLE, count down the latency, one DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            write_r <= 1'b0;
            func3_r <= 3'b000;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        write_r <= bus.mem_write;
                        func3_r <= bus.func3;
                        addr_r  <= bus.address[ADDR_WIDTH-1:0];
                        wdata_r <= bus.write_data;
                        if (LAT_ONE) begin
                            state_r <= ST_DONE;
                            cnt_r   <= 4'd0;
                        end else begin
                            state_r <= ST_ACCESS;
                            cnt_r   <= CNT_START;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_DONE;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Result registers: load data and misalignment flag are updated at the commit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_data_r  <= 32'h0000_0000;
            misaligned_r <= 1'b0;
        end else if (commit_s) begin
            misaligned_r <= c_mis_s;
            if (!c_write_s) begin
                read_data_r <= c_mis_s ? 32'h0000_0000 : load_data_s;
            end
        end else begin
            misaligned_r <= 1'b0;
        end
    end

    // Array write port; contents survive reset but a store caught by reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && commit_s && c_write_s && !c_mis_s) begin
            case (c_func3_s)
                3'b000: mem_r[c_addr_s] <= c_wdata_s[7:0];
                3'b001: begin
                    mem_r[c_addr_s]  <= c_wdata_s[7:0];
                    mem_r[c_addr1_s] <= c_wdata_s[15:8];
                end
                3'b010: begin
                    mem_r[c_addr_s]  <= c_wdata_s[7:0];
                    mem_r[c_addr1_s] <= c_wdata_s[15:8];
                    mem_r[c_addr2_s] <= c_wdata_s[23:16];
                    mem_r[c_addr3_s] <= c_wdata_s[31:24];
                end
                default: ;
            endcase
        end
    end

    assign bus.read_data  = read_data_r;
    assign bus.misaligned = misaligned_r;
    assign bus.busy_wait  = busy_wait_s;
endmodule
